// File: rtl/comb_unpack_if.sv
// Packed-operand link on the input side and the operand beat link on the output side.
// The master modport is the side that sends packed words and takes operand beats.
interface comb_unpack_if #(
    parameter int DW = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_comb;
    logic [DW:0]     in_res;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_op;
    logic            out_last;
    logic            out_err;

    modport master (
        output in_valid, in_comb, in_res, out_ready,
        input  in_ready, out_valid, out_op, out_last, out_err
    );

    modport slave (
        input  in_valid, in_comb, in_res, out_ready,
        output in_ready, out_valid, out_op, out_last, out_err
    );
endinterface

// File: rtl/comb_unpack.sv
// Splits a packed {op1, op2} word into two operand beats, op1 first, and checks the carried sum.
// Keeps saturating counters of emitted packets and of packets whose sum mismatched.
module comb_unpack #(
    parameter int DW        = 32,
    parameter int CHECK_SUM = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    comb_unpack_if.slave     bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    // state  | meaning
    // S_IDLE | no packet held, ready for a packed word
    // S_HI   | presenting op1 beat
    // S_LO   | presenting op2 beat (last); may accept the next word on the same edge
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    hi_q, hi_d;
    logic [DW-1:0]    lo_q, lo_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [DW-1:0]    hi_in;
    logic [DW-1:0]    lo_in;
    logic [DW:0]      sum_in;
    logic             mis_in;
    logic             capture;
    logic             in_ready_c;
    logic             out_valid_c;
    logic [DW-1:0]    out_op_c;
    logic             out_last_c;
    logic             out_err_c;

    assign hi_in  = bus.in_comb[2*DW-1:DW];
    assign lo_in  = bus.in_comb[DW-1:0];
    // Full DW+1 bit sum so a dropped carry in the sender is caught.
    assign sum_in = {1'b0, hi_in} + {1'b0, lo_in};
    assign mis_in = (CHECK_SUM != 0) && (sum_in != bus.in_res);

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mis_d       = mis_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        capture     = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_op_c    = '0;
        out_last_c  = 1'b0;
        out_err_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                out_valid_c = 1'b1;
                out_op_c    = hi_q;
                if (bus.out_ready) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                out_valid_c = 1'b1;
                out_op_c    = lo_q;
                out_last_c  = 1'b1;
                out_err_c   = mis_q;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (pkt_cnt_q != '1) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end
                    if (mis_q && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (bus.in_valid) begin
                        capture = 1'b1;
                        state_d = S_HI;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            hi_d  = hi_in;
            lo_d  = lo_in;
            mis_d = mis_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mis_q     <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mis_q     <= mis_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Handshake outputs are held quiet for the whole time reset is asserted.
    assign bus.in_ready  = rst & in_ready_c;
    assign bus.out_valid = rst & out_valid_c;
    assign bus.out_op    = rst ? out_op_c : '0;
    assign bus.out_last  = rst & out_last_c;
    assign bus.out_err   = rst & out_err_c;

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_comb_unpack.sv
// Bench for comb_unpack: three instances (default, sum check off, 2-bit counters) share one stimulus.
// Expected beats and counts come from a queue model built from accepted words.
module tb_comb_unpack;
    localparam int DW    = 32;
    localparam int MAX_A = 65535;
    localparam int MAX_S = 3;

    typedef struct {
        logic [DW-1:0] op;
        logic          last;
        logic          err;
    } beat_t;

    logic            clk       = 1'b0;
    logic            rst       = 1'b0;
    logic            in_valid  = 1'b0;
    logic [2*DW-1:0] in_comb   = '0;
    logic [DW:0]     in_res    = '0;
    logic            out_ready = 1'b0;

    logic [15:0] pkt_a, err_a, pkt_n, err_n;
    logic [1:0]  pkt_s, err_s;

    comb_unpack_if #(.DW(DW)) bus_a ();
    comb_unpack_if #(.DW(DW)) bus_n ();
    comb_unpack_if #(.DW(DW)) bus_s ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_comb   = in_comb;
    assign bus_a.in_res    = in_res;
    assign bus_a.out_ready = out_ready;
    assign bus_n.in_valid  = in_valid;
    assign bus_n.in_comb   = in_comb;
    assign bus_n.in_res    = in_res;
    assign bus_n.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_comb   = in_comb;
    assign bus_s.in_res    = in_res;
    assign bus_s.out_ready = out_ready;

    comb_unpack #(.DW(DW)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .pkt_cnt(pkt_a), .err_cnt(err_a)
    );
    comb_unpack #(.DW(DW), .CHECK_SUM(0)) u_dut_n (
        .clk(clk), .rst(rst), .bus(bus_n), .pkt_cnt(pkt_n), .err_cnt(err_n)
    );
    comb_unpack #(.DW(DW), .CNT_W(2)) u_dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .pkt_cnt(pkt_s), .err_cnt(err_s)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int m_pkt = 0;
    int m_err = 0;
    beat_t exp_q[$];
    beat_t e;

    logic          s_acc, s_fire, s_valid, s_ready, s_last, s_err, s_err_n;
    logic [DW-1:0] s_op, s_op_n;

    task automatic tick();
        @(negedge clk);
        s_valid = bus_a.out_valid;
        s_ready = bus_a.in_ready;
        s_acc   = in_valid && bus_a.in_ready;
        s_fire  = bus_a.out_valid && out_ready;
        s_op    = bus_a.out_op;
        s_last  = bus_a.out_last;
        s_err   = bus_a.out_err;
        s_op_n  = bus_n.out_op;
        s_err_n = bus_n.out_err;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic model_mis(logic [2*DW-1:0] w, logic [DW:0] r);
        longint a, b;
        a = longint'(w[2*DW-1:DW]);
        b = longint'(w[DW-1:0]);
        return (a + b) != longint'(r);
    endfunction

    function automatic logic [67:0] exp_cnt();
        return {16'(sat(m_pkt, MAX_A)), 16'(sat(m_err, MAX_A)),
                16'(sat(m_pkt, MAX_A)), 16'd0,
                2'(sat(m_pkt, MAX_S)), 2'(sat(m_err, MAX_S))};
    endfunction

    task automatic push_expected();
        logic [2*DW-1:0] w;
        w = in_comb;
        exp_q.push_back('{w[2*DW-1:DW], 1'b0, 1'b0});
        exp_q.push_back('{w[DW-1:0], 1'b1, model_mis(in_comb, in_res)});
    endtask

    task automatic new_packet(input logic corrupt);
        logic [DW-1:0] o1, o2;
        logic [DW:0]   r;
        o1 = $urandom;
        o2 = $urandom;
        if ($urandom_range(0, 4) == 0) o1 = '1;
        r = {1'b0, o1} + {1'b0, o2};
        if (corrupt) r = r ^ (33'h1 << $urandom_range(0, DW));
        in_comb = {o1, o2};
        in_res  = r;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_comb = 64'h00000001_00000002; in_res = 33'h3;
        tick();
        tick();
        n_chk++;
        if ({s_valid, s_ready, s_last, s_err, s_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b r=%b l=%b e=%b op=%h exp all zero", s_valid, s_ready, s_last, s_err, s_op);
        end
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL reset_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        n_chk++;
        if ({s_ready, s_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_idle: got ready=%b valid=%b exp ready=1 valid=0", s_ready, s_valid);
        end
    endtask

    task automatic test_single();
        in_comb = 64'h00000005_00000003; in_res = 33'h0_00000008;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        n_chk++;
        if (s_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: got %b exp 1", s_acc);
        end
        in_valid = 1'b0;
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last, s_ready} !== {1'b1, 32'h5, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_hi: got v=%b op=%h last=%b rdy=%b exp v=1 op=5 last=0 rdy=0", s_valid, s_op, s_last, s_ready);
        end
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last, s_err, s_ready} !== {1'b1, 32'h3, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_lo: got v=%b op=%h last=%b err=%b rdy=%b exp v=1 op=3 last=1 err=0 rdy=1", s_valid, s_op, s_last, s_err, s_ready);
        end
        m_pkt++;
        tick();
        n_chk++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got valid=%b exp 0", s_valid);
        end
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL single_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    task automatic test_sum_check();
        logic [DW:0] res_tab[2];
        logic        mis;
        res_tab[0] = 33'h1_00000000;
        res_tab[1] = 33'h0_00000000;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_comb = 64'hFFFFFFFF_00000001; in_res = res_tab[i];
            mis = model_mis(in_comb, in_res);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            n_chk++;
            if ({s_valid, s_last, s_err, s_err_n} !== {1'b1, 1'b1, mis, 1'b0}) begin
                n_fail++;
                $display("FAIL sum_err[%0d]: got v=%b last=%b err=%b err_nochk=%b exp v=1 last=1 err=%b err_nochk=0", i, s_valid, s_last, s_err, s_err_n, mis);
            end
            m_pkt++;
            if (mis) m_err++;
            tick();
        end
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL sum_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    task automatic test_back_to_back();
        int k;
        k = 0;
        out_ready = 1'b1;
        new_packet($urandom_range(0, 1) == 1);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (cyc == 0) begin
                n_chk++;
                if (s_acc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_first_accept: got %b exp 1", s_acc);
                end
            end else if (cyc <= 8) begin
                n_chk++;
                if ({s_valid, s_ready} !== {1'b1, s_last}) begin
                    n_fail++;
                    $display("FAIL b2b_flow[%0d]: got valid=%b ready=%b exp valid=1 ready=%b", cyc, s_valid, s_ready, s_last);
                end
            end else begin
                n_chk++;
                if (s_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle_after: got valid=%b exp 0", s_valid);
                end
            end
            if (s_fire) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL b2b_extra_beat: got op=%h exp no beat", s_op);
                end else begin
                    e = exp_q.pop_front();
                    n_chk++;
                    if ({s_op, s_last, s_err, s_op_n, s_err_n} !== {e.op, e.last, e.err, e.op, 1'b0}) begin
                        n_fail++;
                        $display("FAIL b2b_beat: got op=%h last=%b err=%b nochk op=%h err=%b exp op=%h last=%b err=%b", s_op, s_last, s_err, s_op_n, s_err_n, e.op, e.last, e.err);
                    end
                    if (e.last) begin
                        m_pkt++;
                        if (e.err) m_err++;
                    end
                end
            end
            if (s_acc) begin
                push_expected();
                k++;
                if (k < 4) new_packet($urandom_range(0, 1) == 1);
                else in_valid = 1'b0;
            end
        end
        n_chk++;
        if ({k, exp_q.size()} !== {32'd4, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b_complete: got accepted=%0d pending=%0d exp 4 and 0", k, exp_q.size());
        end
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL b2b_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    task automatic test_backpressure();
        logic [2*DW-1:0] p1, p2;
        out_ready = 1'b0;
        new_packet(1'b0);
        p1 = in_comb;
        in_valid = 1'b1;
        tick();
        n_chk++;
        if (s_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got %b exp 1", s_acc);
        end
        new_packet(1'b0);
        p2 = in_comb;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({s_valid, s_op, s_last, s_err, s_ready, s_acc} !== {1'b1, p1[2*DW-1:DW], 4'b0000}) begin
                n_fail++;
                $display("FAIL bp_hold_hi[%0d]: got v=%b op=%h last=%b rdy=%b exp v=1 op=%h last=0 rdy=0", i, s_valid, s_op, s_last, s_ready, p1[2*DW-1:DW]);
            end
        end
        out_ready = 1'b1;
        tick();
        n_chk++;
        if ({s_fire, s_op, s_last} !== {1'b1, p1[2*DW-1:DW], 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hi_fire: got fire=%b op=%h last=%b exp fire=1 op=%h last=0", s_fire, s_op, s_last, p1[2*DW-1:DW]);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({s_valid, s_op, s_last, s_err, s_ready, s_acc} !== {1'b1, p1[DW-1:0], 4'b1000}) begin
                n_fail++;
                $display("FAIL bp_hold_lo[%0d]: got v=%b op=%h last=%b rdy=%b exp v=1 op=%h last=1 rdy=0", i, s_valid, s_op, s_last, s_ready, p1[DW-1:0]);
            end
        end
        out_ready = 1'b1;
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last, s_ready, s_acc} !== {1'b1, p1[DW-1:0], 3'b111}) begin
            n_fail++;
            $display("FAIL bp_lo_fire: got v=%b op=%h last=%b rdy=%b acc=%b exp v=1 op=%h last=1 rdy=1 acc=1", s_valid, s_op, s_last, s_ready, s_acc, p1[DW-1:0]);
        end
        in_valid = 1'b0;
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last} !== {1'b1, p2[2*DW-1:DW], 1'b0}) begin
            n_fail++;
            $display("FAIL bp_next_hi: got v=%b op=%h last=%b exp v=1 op=%h last=0", s_valid, s_op, s_last, p2[2*DW-1:DW]);
        end
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last, s_err} !== {1'b1, p2[DW-1:0], 2'b10}) begin
            n_fail++;
            $display("FAIL bp_next_lo: got v=%b op=%h last=%b err=%b exp v=1 op=%h last=1 err=0", s_valid, s_op, s_last, s_err, p2[DW-1:0]);
        end
        m_pkt += 2;
        tick();
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL bp_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    task automatic test_random();
        int            sent;
        logic          stall;
        logic [DW+1:0] held;
        sent = 0; stall = 1'b0; held = '0;
        in_valid = 1'b0;
        new_packet($urandom_range(0, 2) == 0);
        for (int cyc = 0; cyc < 2000 && (sent < 40 || exp_q.size() != 0); cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 40) in_valid = ($urandom_range(0, 2) != 0);
            tick();
            if (stall) begin
                n_chk++;
                if ({s_valid, s_op, s_last, s_err} !== {1'b1, held}) begin
                    n_fail++;
                    $display("FAIL rand_stable: got v=%b op=%h last=%b err=%b exp held v=1 %h", s_valid, s_op, s_last, s_err, held);
                end
            end
            stall = s_valid && !s_fire;
            held  = {s_op, s_last, s_err};
            if (s_fire) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rand_extra_beat: got op=%h exp no beat", s_op);
                end else begin
                    e = exp_q.pop_front();
                    n_chk++;
                    if ({s_op, s_last, s_err, s_op_n, s_err_n} !== {e.op, e.last, e.err, e.op, 1'b0}) begin
                        n_fail++;
                        $display("FAIL rand_beat: got op=%h last=%b err=%b nochk op=%h err=%b exp op=%h last=%b err=%b", s_op, s_last, s_err, s_op_n, s_err_n, e.op, e.last, e.err);
                    end
                    if (e.last) begin
                        m_pkt++;
                        if (e.err) m_err++;
                    end
                end
            end
            if (s_acc) begin
                push_expected();
                sent++;
                in_valid = 1'b0;
                new_packet($urandom_range(0, 2) == 0);
            end
        end
        in_valid = 1'b0;
        tick();
        n_chk++;
        if ({sent, exp_q.size()} !== {32'd40, 32'd0}) begin
            n_fail++;
            $display("FAIL rand_complete: got sent=%0d pending=%0d exp 40 and 0", sent, exp_q.size());
        end
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL rand_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        new_packet(1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();
        n_chk++;
        if ({s_valid, s_last} !== 2'b11) begin
            n_fail++;
            $display("FAIL rmid_in_lo: got v=%b last=%b exp v=1 last=1", s_valid, s_last);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if ({s_valid, s_ready, s_last, s_err, s_op} !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got v=%b r=%b l=%b e=%b op=%h exp all zero", s_valid, s_ready, s_last, s_err, s_op);
        end
        m_pkt = 0; m_err = 0;
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL rmid_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
        rst = 1'b1; out_ready = 1'b1;
        in_comb = 64'h0000000A_0000000B; in_res = 33'h15; in_valid = 1'b1;
        tick();
        n_chk++;
        if (s_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_accept: got %b exp 1", s_acc);
        end
        in_valid = 1'b0;
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last} !== {1'b1, 32'hA, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_hi: got v=%b op=%h last=%b exp v=1 op=a last=0", s_valid, s_op, s_last);
        end
        tick();
        n_chk++;
        if ({s_valid, s_op, s_last, s_err} !== {1'b1, 32'hB, 2'b10}) begin
            n_fail++;
            $display("FAIL rmid_lo: got v=%b op=%h last=%b err=%b exp v=1 op=b last=1 err=0", s_valid, s_op, s_last, s_err);
        end
        m_pkt++;
        tick();
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL rmid_after_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    task automatic test_saturation();
        int k;
        k = 0;
        out_ready = 1'b1;
        new_packet(1'b1);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && (k < 6 || exp_q.size() != 0); cyc++) begin
            tick();
            if (s_fire && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if ({s_op, s_last, s_err} !== {e.op, e.last, e.err}) begin
                    n_fail++;
                    $display("FAIL sat_beat: got op=%h last=%b err=%b exp op=%h last=%b err=%b", s_op, s_last, s_err, e.op, e.last, e.err);
                end
                if (e.last) begin
                    m_pkt++;
                    if (e.err) m_err++;
                end
            end
            if (s_acc) begin
                push_expected();
                k++;
                if (k < 6) new_packet(k < 5);
                else in_valid = 1'b0;
            end
        end
        tick();
        n_chk++;
        if ({k, exp_q.size(), pkt_s, err_s} !== {32'd6, 32'd0, 2'd3, 2'd3}) begin
            n_fail++;
            $display("FAIL sat_hold: got sent=%0d pending=%0d pkt=%0d err=%0d exp 6 0 3 3", k, exp_q.size(), pkt_s, err_s);
        end
        n_chk++;
        if ({pkt_a, err_a, pkt_n, err_n, pkt_s, err_s} !== exp_cnt()) begin
            n_fail++;
            $display("FAIL sat_counters: got %h exp %h", {pkt_a, err_a, pkt_n, err_n, pkt_s, err_s}, exp_cnt());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sum_check();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns exp finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/comb_unpack.md
Name: comb_unpack

Overview:
- Receive-side counterpart of the operand packer. The packer emits a 64-bit concatenated word {op1, op2} plus a 33-bit sum.
- This block accepts one packed word per handshake and replays it as two 32-bit operand beats: op1 first, then op2.
- It checks the carried sum against op1+op2 and keeps packet and error counters.
- It sits between the packed-operand link and downstream 32-bit datapath consumers.

Parameters:
- DW, 32, operand width. The packed word is 2*DW bits and the sum is DW+1 bits.
- CHECK_SUM, 1, when 1 the sum is compared; when 0 out_err is always 0 and err_cnt never increments.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 resets on the next rising clk edge).
- in_valid  input  1  packed word present.
- in_ready  output  1  block can accept a packed word this cycle.
- in_comb  input  2*DW  packed word; [2*DW-1:DW]=op1, [DW-1:0]=op2.
- in_res  input  DW+1  sum carried by the sender, expected equal to op1+op2.
- out_valid  output  1  operand beat present.
- out_ready  input  1  downstream accepts the beat.
- out_op  output  DW  operand beat data.
- out_last  output  1  high on the op2 beat.
- out_err  output  1  high on the op2 beat when the sum mismatched.
- pkt_cnt  output  CNT_W  count of fully emitted packets; saturates at all-ones.
- err_cnt  output  CNT_W  count of mismatched packets emitted; saturates at all-ones.

Behaviour:
- Handshake: a transfer occurs when valid && ready on the rising edge.
  - out_valid, out_op, out_last and out_err hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Internal storage: registers hi (DW), lo (DW) and mis (1 bit). mis is captured at input accept as (CHECK_SUM && ({1'b0,hi_in}+{1'b0,lo_in} != in_res)). The addition is DW+1 bits wide, so the carry-out is compared.
- FSM states: IDLE, HI, LO.
  - IDLE: out_valid=0, in_ready=1. On in_valid, capture the word and mis, then go to HI.
  - HI: out_valid=1, out_op=hi, out_last=0, out_err=0, in_ready=0. On out_ready, go to LO.
  - LO: out_valid=1, out_op=lo, out_last=1, out_err=mis, in_ready=out_ready (combinational). On out_ready:
    - pkt_cnt increments; err_cnt increments if mis.
    - If in_valid is also high, capture the new word and go to HI (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Latency: the first beat appears the cycle after input accept. Sustained throughput is one packet per 2 cycles with out_ready held high.
- in_ready depends combinationally only on state and out_ready, never on in_valid.
- Counters saturate: at all-ones they hold. A saturated pkt_cnt does not block err_cnt, and vice versa.
- Reset (rst==0 at an edge): state=IDLE, hi=lo=0, mis=0, pkt_cnt=err_cnt=0.
  - While rst==0: out_valid=0, in_ready=0, out_op=0, out_last=0, out_err=0.
  - Reset mid-packet discards the packet with no counter update.
  - The first accept is possible on the first edge after rst returns high.
- in_valid while in HI is not accepted; the sender holds it.

Test Plan:
- Single packet: in_comb=0x00000005_00000003, in_res=0x0_00000008, out_ready=1 → beat 0x5 (last=0), then 0x3 (last=1, err=0); pkt_cnt=1, err_cnt=0.
- Sum mismatch and carry: op1=0xFFFFFFFF, op2=0x1, in_res=0x1_00000000 → err=0. Repeat with in_res=0x0_00000000 → err=1 on last beat, err_cnt=1. With CHECK_SUM=0 → err=0 and err_cnt=0.
- Back-to-back: 4 packets with in_valid and out_ready held high → 8 consecutive beats, no idle cycle, in_ready high only in LO cycles, pkt_cnt=4.
- Backpressure: out_ready low for 3 cycles during HI, then during LO → out_op and out_last held stable, in_ready=0 throughout, no beat duplicated or lost.
- Reset mid-operation: rst=0 while in LO → out_valid=0 next cycle and counters=0. After rst=1, a new packet 0xA/0xB is emitted normally.
- Saturation (CNT_W=2): 5 mismatched packets → pkt_cnt=3, err_cnt=3, and both hold at 3.
